// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the MEM-stage load/store port.
//   SZ_*         access size encodings (byte/half/word/dword)
//   lsu_state_t  transaction FSM states
//   lane_mask()  byte-lane strobe of an access, up to two beats (16 lanes)
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_t;

  // (1<<size) contiguous byte lanes starting at lane 'off'; the upper half
  // covers the second beat of an access that crosses a word boundary.
  function automatic logic [15:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] ones;
    ones = (16'd1 << (5'd1 << size)) - 16'd1;
    return ones << off;
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: pipeline request/response and data-memory handshake of
// the load/store port.
//   req_*   pipeline request (valid/ready, we, size, unsigned, addr, wdata)
//   resp_*  one-cycle completion (valid, extended rdata, fault), stall_o
//   mem_*   memory request/grant, aligned addr, strobes, wdata, rvalid/rdata
// Modports: slave = the port itself, master = pipeline + memory environment.
interface lsu_mem_port_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);
  localparam int unsigned NB = XLEN / 8;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [1:0]        req_size_i;
  logic              req_unsigned_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [XLEN-1:0]   req_wdata_i;
  logic              resp_valid_o;
  logic [XLEN-1:0]   resp_rdata_o;
  logic              resp_fault_o;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [NB-1:0]     mem_wmask_o;
  logic [XLEN-1:0]   mem_wdata_o;
  logic              mem_rvalid_i;
  logic [XLEN-1:0]   mem_rdata_i;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, stall_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_fault_o, stall_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wmask_o, mem_wdata_o
  );

endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for lsu_mem_port.
//   size_i/unsigned_i/off_i  latched access size, extension mode, lane offset
//   beat_i, we_i             current beat (0/1), store flag
//   wdata_i                  LSB-justified store data
//   rdata_i, hold_i          memory read data, current holding register
//   two_beat_o               access crosses a word boundary
//   mask_o, wdata_o          strobes and lane-positioned data for this beat
//   hold_merge_o             holding register after absorbing rdata_i
//   ext_o                    holding register truncated and sign/zero extended
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [1:0]                   size_i,
  input  logic                         unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0]    off_i,
  input  logic                         beat_i,
  input  logic                         we_i,
  input  logic [XLEN-1:0]              wdata_i,
  input  logic [XLEN-1:0]              rdata_i,
  input  logic [XLEN-1:0]              hold_i,
  output logic                         two_beat_o,
  output logic [XLEN/8-1:0]            mask_o,
  output logic [XLEN-1:0]              wdata_o,
  output logic [XLEN-1:0]              hold_merge_o,
  output logic [XLEN-1:0]              ext_o
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  logic [15:0]     full;
  logic [4:0]      span;
  logic [OFFW:0]   nb_minus_off;
  logic [OFFW+2:0] sh_lo;
  logic [OFFW+3:0] sh_hi;
  logic [XLEN-1:0] keep;
  logic            sign;

  always_comb begin
    full         = lane_mask(size_i, 3'(off_i));
    span         = 5'(off_i) + (5'd1 << size_i);
    two_beat_o   = span > 5'(NB);
    nb_minus_off = (OFFW+1)'(NB) - {1'b0, off_i};
    sh_lo        = {off_i, 3'b000};
    sh_hi        = {nb_minus_off, 3'b000};

    mask_o  = '0;
    wdata_o = wdata_i << sh_lo;
    if (beat_i) begin
      wdata_o = wdata_i >> sh_hi;
    end
    if (we_i) begin
      mask_o = beat_i ? full[2*NB-1:NB] : full[NB-1:0];
    end

    // Beat 0 brings the low part of the access down to lane 0; beat 1
    // supplies the remaining bytes just above it.
    hold_merge_o = beat_i ? (hold_i | (rdata_i << sh_hi)) : (rdata_i >> sh_lo);
  end

  always_comb begin
    keep = '1;
    sign = 1'b0;
    case (size_i)
      SZ_B:    begin keep = XLEN'(8'hFF);         sign = hold_i[7];  end
      SZ_H:    begin keep = XLEN'(16'hFFFF);      sign = hold_i[15]; end
      SZ_W:    begin keep = XLEN'(32'hFFFF_FFFF); sign = hold_i[31]; end
      default: begin keep = '1;                   sign = 1'b0;       end
    endcase
    ext_o = (hold_i & keep) | ((sign && !unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: MEM-stage load/store port. Accepts one request at a time,
// issues one or two aligned memory beats over a req/gnt/rvalid handshake and
// returns a one-cycle response with the extended load data or a fault.
//   clk, rst  clock (rising edge), synchronous active-high reset
//   bus       lsu_mem_port_if.slave: pipeline req/resp and memory side
// Parameters: XLEN (32/64), ADDR_W, SPLIT_MISALIGNED (1: two beats, 0: fault).
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN             = 64,
  parameter int unsigned ADDR_W           = 64,
  parameter int unsigned SPLIT_MISALIGNED = 1
) (
  input  logic          clk,
  input  logic          rst,
  lsu_mem_port_if.slave bus
);
  localparam int unsigned NB   = XLEN / 8;
  localparam int unsigned OFFW = $clog2(NB);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              beat_q, beat_d;
  logic [XLEN-1:0]   hold_q, hold_d;
  logic              fault_q, fault_d;

  logic              two_beat;
  logic [NB-1:0]     beat_mask;
  logic [XLEN-1:0]   beat_wdata;
  logic [XLEN-1:0]   hold_merge;
  logic [XLEN-1:0]   ext_data;
  logic [2:0]        align_mask;
  logic              req_fault;
  logic [ADDR_W-1:0] base_addr;

  lsu_lane_align #(.XLEN(XLEN)) u_align (
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .off_i        (addr_q[OFFW-1:0]),
    .beat_i       (beat_q),
    .we_i         (we_q),
    .wdata_i      (wdata_q),
    .rdata_i      (bus.mem_rdata_i),
    .hold_i       (hold_q),
    .two_beat_o   (two_beat),
    .mask_o       (beat_mask),
    .wdata_o      (beat_wdata),
    .hold_merge_o (hold_merge),
    .ext_o        (ext_data)
  );

  // The fault decision uses the incoming request so a faulted access can
  // respond in the very next cycle; it equals the check on the latched copy.
  always_comb begin
    align_mask = 3'((4'd1 << bus.req_size_i) - 4'd1);
    req_fault  = ((XLEN == 32) && (bus.req_size_i == SZ_D)) ||
                 ((|(bus.req_addr_i[2:0] & align_mask)) && (SPLIT_MISALIGNED == 0));
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          size_d  = bus.req_size_i;
          uns_d   = bus.req_unsigned_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          beat_d  = 1'b0;
          hold_d  = '0;
          fault_d = req_fault;
          state_d = req_fault ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid_i) begin
          hold_d = hold_merge;
          if (!beat_q && two_beat) begin
            beat_d  = 1'b1;
            state_d = ST_REQ;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= 1'b0;
      hold_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    base_addr        = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    bus.req_ready_o  = (state_q == ST_IDLE);
    bus.stall_o      = (state_q != ST_IDLE) || bus.req_valid_i;
    bus.mem_req_o    = (state_q == ST_REQ);
    bus.mem_we_o     = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_wmask_o  = '0;
    bus.mem_wdata_o  = '0;
    if (state_q == ST_REQ) begin
      bus.mem_we_o    = we_q;
      bus.mem_addr_o  = beat_q ? (base_addr + ADDR_W'(NB)) : base_addr;
      bus.mem_wmask_o = beat_mask;
      bus.mem_wdata_o = we_q ? beat_wdata : '0;
    end
    bus.resp_valid_o = (state_q == ST_RESP);
    bus.resp_fault_o = (state_q == ST_RESP) && fault_q;
    bus.resp_rdata_o = ((state_q == ST_RESP) && !we_q && !fault_q) ? ext_data : '0;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
  import lsu_pkg::*;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned ADDR_W = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_port_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();
  lsu_mem_port_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus_ns ();

  lsu_mem_port #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SPLIT_MISALIGNED(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  lsu_mem_port #(.XLEN(XLEN), .ADDR_W(ADDR_W), .SPLIT_MISALIGNED(0)) dut_ns (
    .clk(clk), .rst(rst), .bus(bus_ns.slave));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference memory and behavioural model ----------------
  logic [7:0] mem_dut [128];
  logic [7:0] mem_ref [128];

  typedef struct packed { logic [63:0] rdata; logic fault; } exp_t;
  exp_t exp_q[$];

  function automatic int bidx(input logic [63:0] a, input int i);
    return (int'(a[6:0]) + i) % 128;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input logic [1:0] sz, input logic uns);
    int n;
    logic [63:0] v;
    n = 1 << sz;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mem_ref[bidx(a, i)]) << (8 * i));
    if (!uns && n < 8 && (((v >> (8 * n - 1)) & 64'd1) != 0)) v = v | ({64{1'b1}} << (8 * n));
    return v;
  endfunction

  function automatic logic ref_fault(input logic [63:0] a, input logic [1:0] sz, input int split);
    return ((a % (64'd1 << sz)) != 0) && (split == 0);
  endfunction

  task automatic set_byte(input logic [63:0] a, input logic [7:0] v);
    mem_dut[bidx(a, 0)] = v;
    mem_ref[bidx(a, 0)] = v;
  endtask

  // ---------------- memory responder ----------------
  typedef struct packed { logic [63:0] addr; logic [7:0] mask; logic [63:0] wdata; logic we; } beat_t;
  beat_t beats[$];
  bit rand_mode = 0;
  int gnt_fixed = 0, rv_fixed = 0;
  int gcnt = 0, gtarget = 0, rcnt = 0;
  bit pending = 0;
  logic [63:0] pend_data;

  task automatic set_lat(input int g, input int r);
    gnt_fixed = g;
    rv_fixed  = r;
    gtarget   = g;
    gcnt      = 0;
  endtask

  initial begin
    beat_t b;
    int base;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (pending) begin
        if (rcnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i = pend_data;
          pending = 0;
        end else rcnt--;
      end else if (bus.mem_req_o) begin
        if (gcnt < gtarget) gcnt++;
        else begin
          bus.mem_gnt_i = 1'b1;
          gcnt = 0;
          gtarget = rand_mode ? int'($urandom_range(0, 3)) : gnt_fixed;
          rcnt    = rand_mode ? int'($urandom_range(0, 3)) : rv_fixed;
          b.addr = bus.mem_addr_o; b.mask = bus.mem_wmask_o;
          b.wdata = bus.mem_wdata_o; b.we = bus.mem_we_o;
          beats.push_back(b);
          base = int'(b.addr[6:0]);
          for (int i = 0; i < 8; i++) begin
            if (b.we && b.mask[i]) mem_dut[(base + i) % 128] = 8'(b.wdata >> (8 * i));
            pend_data[8*i +: 8] = mem_dut[(base + i) % 128];
          end
          pending = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int resp_count = 0;
  int last_resp_cyc = 0;
  logic [63:0] last_rdata;
  logic last_fault;

  initial begin
    exp_t e;
    logic pr_req, pr_gnt, pr_we;
    logic [63:0] pr_addr, pr_wd;
    logic [7:0] pr_mask;
    pr_req = 0; pr_gnt = 0; pr_we = 0; pr_addr = '0; pr_wd = '0; pr_mask = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pr_req = 0;
        continue;
      end
      chk("stall", bus.stall_o, !bus.req_ready_o || bus.req_valid_i);
      if (bus.resp_valid_o) begin
        resp_count++;
        last_resp_cyc = cyc;
        last_rdata = bus.resp_rdata_o;
        last_fault = bus.resp_fault_o;
        if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("resp_rdata", bus.resp_rdata_o, e.rdata);
          chk("resp_fault", bus.resp_fault_o, e.fault);
        end
      end
      if (bus.mem_req_o) begin
        chk("mem_addr_align", bus.mem_addr_o[2:0], 0);
        if (!bus.mem_we_o) chk("mem_wmask_read", bus.mem_wmask_o, 0);
        if (pr_req && !pr_gnt) begin
          chk("hold_addr", bus.mem_addr_o, pr_addr);
          chk("hold_mask", bus.mem_wmask_o, pr_mask);
          chk("hold_wdata", bus.mem_wdata_o, pr_wd);
          chk("hold_we", bus.mem_we_o, pr_we);
        end
      end
      pr_req = bus.mem_req_o; pr_gnt = bus.mem_gnt_i; pr_we = bus.mem_we_o;
      pr_addr = bus.mem_addr_o; pr_wd = bus.mem_wdata_o; pr_mask = bus.mem_wmask_o;
    end
  end

  // ---------------- request driver ----------------
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [63:0] a, input logic [63:0] wd,
                       input bit wait_resp, output int lat);
    int n, rc0, t0;
    exp_t e;
    lat = -1;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 100) begin @(negedge clk); n++; end
    if (!bus.req_ready_o) begin
      checks++; errors++;
      $display("FAIL ready_timeout: req_ready_o got 0 expected 1");
      return;
    end
    e.fault = ref_fault(a, sz, 1);
    e.rdata = (we || e.fault) ? 64'd0 : ref_load(a, sz, uns);
    if (we && !e.fault)
      for (int i = 0; i < (1 << sz); i++) mem_ref[bidx(a, i)] = 8'(wd >> (8 * i));
    exp_q.push_back(e);
    rc0 = resp_count;
    t0 = cyc;
    bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = sz;
    bus.req_unsigned_i = uns; bus.req_addr_i = a; bus.req_wdata_i = wd;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    if (!wait_resp) return;
    n = 0;
    while (resp_count == rc0 && n < 100) begin @(negedge clk); n++; end
    if (resp_count == rc0) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid_o got 0 expected 1 within 100 cycles");
      return;
    end
    lat = last_resp_cyc - t0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, rc0;
    logic [63:0] a, wd, v;
    logic [1:0] sz;
    logic we, uns, two;

    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_size_i = '0; bus.req_unsigned_i = 0;
    bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus_ns.req_valid_i = 0; bus_ns.req_we_i = 0; bus_ns.req_size_i = '0; bus_ns.req_unsigned_i = 0;
    bus_ns.req_addr_i = '0; bus_ns.req_wdata_i = '0;
    bus_ns.mem_gnt_i = 0; bus_ns.mem_rvalid_i = 0; bus_ns.mem_rdata_i = '0;
    for (int i = 0; i < 128; i++) begin
      mem_dut[i] = 8'($urandom);
      mem_ref[i] = mem_dut[i];
    end
    set_lat(0, 0);

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready_o, 1);
    chk("rst_resp_valid", bus.resp_valid_o, 0);
    chk("rst_resp_rdata", bus.resp_rdata_o, 0);
    chk("rst_resp_fault", bus.resp_fault_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_wmask", bus.mem_wmask_o, 0);
    @(negedge clk);
    rst = 0;

    // aligned LD
    v = 64'h1122334455667788;
    for (int i = 0; i < 8; i++) set_byte(64'h1000 + 64'(i), 8'(v >> (8 * i)));
    beats.delete();
    issue(0, SZ_D, 0, 64'h1000, '0, 1, lat);
    chk("ld_rdata", last_rdata, 64'h1122334455667788);
    chk("ld_latency", 64'(lat), 3);
    chk("ld_wmask", 64'(beats[0].mask), 0);
    chk("ld_addr", beats[0].addr, 64'h1000);

    // LB / LBU
    set_byte(64'h1003, 8'h80);
    issue(0, SZ_B, 0, 64'h1003, '0, 1, lat);
    chk("lb_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    issue(0, SZ_B, 1, 64'h1003, '0, 1, lat);
    chk("lbu_rdata", last_rdata, 64'h0000_0000_0000_0080);

    // SH with grant delayed 3 cycles
    set_lat(3, 0);
    beats.delete();
    issue(1, SZ_H, 0, 64'h1006, 64'hABCD, 1, lat);
    chk("sh_beats", 64'(beats.size()), 1);
    chk("sh_addr", beats[0].addr, 64'h1000);
    chk("sh_mask", 64'(beats[0].mask), 64'hC0);
    chk("sh_wdata", 64'(beats[0].wdata[63:48]), 64'hABCD);
    chk("sh_latency", 64'(lat), 6);
    chk("sh_store_resp", last_rdata, 0);
    set_lat(0, 0);

    // misaligned SW, split into two beats
    beats.delete();
    issue(1, SZ_W, 0, 64'h1006, 64'hDEADBEEF, 1, lat);
    chk("sw_beats", 64'(beats.size()), 2);
    chk("sw_b0_addr", beats[0].addr, 64'h1000);
    chk("sw_b0_mask", 64'(beats[0].mask), 64'hC0);
    chk("sw_b0_data", 64'(beats[0].wdata[63:48]), 64'hBEEF);
    chk("sw_b1_addr", beats[1].addr, 64'h1008);
    chk("sw_b1_mask", 64'(beats[1].mask), 64'h03);
    chk("sw_b1_data", 64'(beats[1].wdata[15:0]), 64'hDEAD);
    chk("sw_latency", 64'(lat), 5);

    // misaligned LW, signed
    set_byte(64'h1007, 8'h44); set_byte(64'h1008, 8'h33);
    set_byte(64'h1009, 8'h22); set_byte(64'h100A, 8'h11);
    issue(0, SZ_W, 0, 64'h1007, '0, 1, lat);
    chk("lw_mis_pos", last_rdata, 64'h0000_0000_1122_3344);
    chk("lw_mis_latency", 64'(lat), 5);
    set_byte(64'h100A, 8'h91);
    issue(0, SZ_W, 0, 64'h1007, '0, 1, lat);
    chk("lw_mis_neg", last_rdata, 64'hFFFF_FFFF_9122_3344);

    // split disabled: misaligned SW faults without touching memory
    @(negedge clk);
    bus_ns.req_valid_i = 1; bus_ns.req_we_i = 1; bus_ns.req_size_i = SZ_W;
    bus_ns.req_addr_i = 64'h1006; bus_ns.req_wdata_i = 64'hDEADBEEF;
    #1;
    chk("ns_stall_req", bus_ns.stall_o, 1);
    @(negedge clk);
    bus_ns.req_valid_i = 0;
    #1;
    chk("ns_resp_valid", bus_ns.resp_valid_o, 1);
    chk("ns_resp_fault", bus_ns.resp_fault_o, 1);
    chk("ns_resp_rdata", bus_ns.resp_rdata_o, 0);
    chk("ns_mem_req", bus_ns.mem_req_o, 0);
    @(negedge clk);
    #1;
    chk("ns_resp_once", bus_ns.resp_valid_o, 0);
    chk("ns_ready", bus_ns.req_ready_o, 1);
    chk("ns_mem_req_after", bus_ns.mem_req_o, 0);

    // reset while waiting for read data
    set_lat(0, 6);
    issue(0, SZ_D, 0, 64'h1000, '0, 0, lat);
    @(negedge clk);
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("rst_mid_mem_req", bus.mem_req_o, 0);
    chk("rst_mid_ready", bus.req_ready_o, 1);
    @(negedge clk);
    rst = 0;
    rc0 = resp_count;
    repeat (10) @(negedge clk);
    chk("rst_mid_no_resp", 64'(resp_count), 64'(rc0));
    chk("rst_mid_rvalid_done", 64'(pending), 0);
    set_lat(0, 0);
    issue(0, SZ_D, 0, 64'h1000, '0, 1, lat);
    chk("post_rst_latency", 64'(lat), 3);

    // randomized traffic against the model
    rand_mode = 1;
    gtarget = 0;
    for (int k = 0; k < 300; k++) begin
      we  = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      a   = 64'h1000 + 64'($urandom_range(0, 63));
      wd  = {$urandom, $urandom};
      two = ((a % 8) + (64'd1 << sz)) > 8;
      issue(we, sz, uns, a, wd, 1, lat);
      chk("lat_min", 64'(lat >= (two ? 5 : 3)), 1);
    end
    rand_mode = 0;
    repeat (3) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    for (int i = 0; i < 128; i++) chk("mem_byte", 64'(mem_dut[i]), 64'(mem_ref[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
